// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : MEM-stage data-port responder; word RAM with programmable wait
//            states, stall output, one-cycle done pulse and access-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int                 c_CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_INIT = c_CNT_W'(WAIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rd_op;
    logic               r_wr_op;
    logic [31:0]        r_addr;
    logic [31:0]        r_wd;
    logic [31:0]        r_rd;
    logic               r_done;
    logic               r_err;
    logic [31:0]        r_mem [0:(1 << ADDR_W)-1];

    logic               w_req;
    logic               w_err;
    logic               w_mem_we;
    logic [ADDR_W-1:0]  w_idx;

    assign w_req = MemRead | MemWrite;
    assign w_idx = r_addr[ADDR_W+1:2];
    assign w_err = (r_addr[1:0] != 2'b00)
                 | (r_addr[31:ADDR_W+2] != '0)
                 | (r_rd_op & r_wr_op);

    // Gating with rst keeps a write abandoned by reset from landing in the array.
    assign w_mem_we = (r_state == c_ACCESS) & r_wr_op & ~w_err & rst;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_rd_op <= 1'b0;
            r_wr_op <= 1'b0;
            r_addr  <= '0;
            r_wd    <= '0;
            r_rd    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_req) begin
                        r_rd_op <= MemRead;
                        r_wr_op <= MemWrite;
                        r_addr  <= addr;
                        r_wd    <= wd;
                        r_cnt   <= c_WAIT_INIT;
                        r_state <= (WAIT_CYCLES > 0) ? c_WAIT : c_ACCESS;
                    end
                end
                c_WAIT: begin
                    // Exit on 1 so the counter never wraps below zero.
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= c_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_ACCESS: begin
                    if (r_rd_op & ~w_err) begin
                        r_rd <= r_mem[w_idx];
                    end
                    r_done  <= 1'b1;
                    r_err   <= w_err;
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy = (r_state == c_WAIT) | (r_state == c_ACCESS) | ((r_state == c_IDLE) & w_req);
    end

    assign rd   = r_rd;
    assign done = r_done;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Scoreboard bench for dmem_responder (WAIT_CYCLES=2 and 0 units).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int c_W0 = 2;
    localparam int c_W1 = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mr   [2];
    logic        mw   [2];
    logic [31:0] ad   [2];
    logic [31:0] wdv  [2];
    logic [31:0] rdo  [2];
    logic        busy [2];
    logic        done [2];
    logic        err  [2];

    int          cyc;
    int          n_checks;
    int          n_errors;
    int          ndone     [2];
    int          last_done [2];
    int          prev_done [2];
    logic [31:0] mrd       [2];
    logic [31:0] mm        [int];
    exp_t        q0        [$];
    exp_t        q1        [$];

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(c_W0)) u_dut0 (
        .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]),
        .addr(ad[0]), .wd(wdv[0]), .rd(rdo[0]), .busy(busy[0]),
        .done(done[0]), .err(err[0])
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(c_W1)) u_dut1 (
        .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]),
        .addr(ad[1]), .wd(wdv[1]), .rd(rdo[1]), .busy(busy[1]),
        .done(done[1]), .err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every done pulse pops one expected result.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (done[u] === 1'b1) begin
                    ndone[u]++;
                    prev_done[u] = last_done[u];
                    last_done[u] = cyc;
                    if ((u == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                        chk("sb_unexpected_done", 32'd1, 32'd0);
                    end else begin
                        x = (u == 0) ? q0.pop_front() : q1.pop_front();
                        chk("sb_rd", rdo[u], x.rd);
                        chk("sb_err", 32'(err[u]), 32'(x.err));
                    end
                end
            end
        end
    end

    // Drive one request, push its expected result, and check busy/done timing.
    task automatic req(input int u, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        int   wt;
        int   key;
        logic e;
        exp_t x;
        wt = (u == 0) ? c_W0 : c_W1;
        @(posedge clk);
        #1;
        mr[u]  = r;
        mw[u]  = w;
        ad[u]  = a;
        wdv[u] = d;
        e   = (a[1:0] != 2'b00) || (a[31:12] != 20'h0) || (r && w);
        key = u * 4096 + int'(a[11:2]);
        if (!e && w) mm[key] = d;
        if (!e && r) mrd[u] = mm.exists(key) ? mm[key] : 32'h0;
        x.rd  = mrd[u];
        x.err = e;
        if (u == 0) q0.push_back(x);
        else        q1.push_back(x);
        for (int i = 0; i < wt + 2; i++) begin
            @(negedge clk);
            chk("busy_inflight", 32'(busy[u]), 32'd1);
            chk("done_early", 32'(done[u]), 32'd0);
        end
        @(negedge clk);
        chk("done_pulse", 32'(done[u]), 32'd1);
        chk("busy_in_done", 32'(busy[u]), 32'd0);
    endtask

    task automatic idle(input int u);
        @(posedge clk);
        #1;
        mr[u] = 1'b0;
        mw[u] = 1'b0;
        @(negedge clk);
        chk("no_second_done", 32'(done[u]), 32'd0);
        chk("idle_busy", 32'(busy[u]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int u = 0; u < 2; u++) begin
            mr[u] = 0; mw[u] = 0; ad[u] = '0; wdv[u] = '0;
            mrd[u] = '0; ndone[u] = 0; last_done[u] = 0; prev_done[u] = 0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rd", rdo[0], 32'h0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);

        // Basic write/read, rd unaffected by writes
        req(0, 0, 1, 32'h40, 32'hDEADBEEF); idle(0);
        req(0, 1, 0, 32'h40, 32'h0);        idle(0);
        req(0, 0, 1, 32'h44, 32'h12345678); idle(0);
        req(0, 1, 0, 32'h44, 32'h0);        idle(0);
        req(0, 1, 0, 32'h40, 32'h0);        idle(0);

        // Error cases: misaligned (aliases index of 0x40), out of range, read+write
        req(0, 0, 1, 32'h42, 32'hBAD0BAD0);   idle(0);
        req(0, 1, 0, 32'h1000, 32'h0);        idle(0);
        req(0, 1, 1, 32'h44, 32'h0BADF00D);   idle(0);

        // Back-to-back reads confirm memory untouched by the faulty accesses
        req(0, 1, 0, 32'h40, 32'h0);
        req(0, 1, 0, 32'h44, 32'h0);
        idle(0);
        chk("b2b_spacing", 32'(last_done[0] - prev_done[0]), 32'(c_W0 + 3));

        // Reset during WAIT of a write abandons it
        req(0, 0, 1, 32'h80, 32'h11110080); idle(0);
        @(posedge clk);
        #1;
        mw[0] = 1'b1; ad[0] = 32'h80; wdv[0] = 32'hCAFEF00D;
        @(posedge clk);
        #2;
        rst   = 1'b0;
        mw[0] = 1'b0;
        #1;
        chk("async_rst_rd", rdo[0], 32'h0);
        chk("async_rst_busy", 32'(busy[0]), 32'd0);
        chk("async_rst_done", 32'(done[0]), 32'd0);
        chk("async_rst_err", 32'(err[0]), 32'd0);
        mrd[0] = '0;
        mrd[1] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req(0, 1, 0, 32'h80, 32'h0); idle(0);

        // Zero-wait instance; request held through DONE gives one pulse each
        req(1, 0, 1, 32'h8, 32'hA5A5A5A5); idle(1);
        req(1, 1, 0, 32'h8, 32'h0);        idle(1);
        repeat (2) @(negedge clk);
        chk("w0_done_count", 32'(ndone[1]), 32'd2);

        chk("sb0_drained", 32'(q0.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
